// File: rtl/sdram_uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sdram_uart_cmd_pkg
// Brief    : State encoding, ASCII constants and hex helpers for the UART
//            SDRAM command front-end.
// Revision : 1.0  initial release
// ============================================================================
package sdram_uart_cmd_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WR_WAIT = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_RD_DATA = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_TX_HI   = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_TX_LO   = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_TX_SP   = 3'd6;

    localparam logic [7:0] c_ASCII_AT  = 8'h40;
    localparam logic [7:0] c_ASCII_W   = 8'h77;
    localparam logic [7:0] c_ASCII_R   = 8'h72;
    localparam logic [7:0] c_ASCII_X   = 8'h78;
    localparam logic [7:0] c_ASCII_DOT = 8'h2E;
    localparam logic [7:0] c_ASCII_QM  = 8'h3F;
    localparam logic [7:0] c_ASCII_SP  = 8'h20;

    // Returns {valid, nibble}; accepts both letter cases.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] result;
        result = 5'b0_0000;
        if (b >= 8'h30 && b <= 8'h39) begin
            result = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            result = {1'b1, b[3:0] + 4'd9};
        end
        return result;
    endfunction

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_nibble_ascii.sv
`default_nettype none
// ============================================================================
// Module   : hex_nibble_ascii
// Brief    : Combinational ASCII hex-digit decode and lowercase nibble encode.
// Revision : 1.0  initial release
// ============================================================================
module hex_nibble_ascii
    import sdram_uart_cmd_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_valid,
    output logic [3:0] o_nibble,
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    logic [4:0] w_decoded;

    always_comb begin
        w_decoded = hex_decode(i_byte);
        o_ascii   = nibble_to_ascii(i_nibble);
    end

    assign o_valid  = w_decoded[4];
    assign o_nibble = w_decoded[3:0];

endmodule
`default_nettype wire

// File: rtl/sdram_uart_cmd.sv
`default_nettype none
// ============================================================================
// Module   : sdram_uart_cmd
// Brief    : ASCII command parser issuing single-byte SDRAM reads/writes and
//            returning read data as hex text to the UART transmit FIFO.
// Revision : 1.0  initial release
// ============================================================================
module sdram_uart_cmd #(
    parameter int ADDR_WIDTH   = 25,
    parameter int TIMEOUT      = 1024,
    parameter int TIMEOUT_BITS = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic [7:0]            tx_data,
    output logic                  tx_strobe,
    output logic [ADDR_WIDTH-1:0] sd_wr_addr,
    output logic [7:0]            sd_wr_data,
    output logic                  sd_wr_enable,
    output logic [ADDR_WIDTH-1:0] sd_rd_addr,
    output logic                  sd_rd_enable,
    input  logic [7:0]            sd_rd_data,
    input  logic                  sd_rd_ready,
    input  logic                  sd_busy,
    output logic                  overrun
);

    import sdram_uart_cmd_pkg::*;

    logic [c_STATE_W-1:0]    r_state_q,     w_state_d;
    logic [ADDR_WIDTH-1:0]   r_acc_q,       w_acc_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q,      w_addr_d;
    logic [7:0]              r_wdata_q,     w_wdata_d;
    logic [7:0]              r_rdata_q,     w_rdata_d;
    logic [TIMEOUT_BITS-1:0] r_timer_q,     w_timer_d;
    logic [7:0]              r_tx_data_q,   w_tx_data_d;
    logic                    r_tx_strobe_q, w_tx_strobe_d;
    logic [ADDR_WIDTH-1:0]   r_wr_addr_q,   w_wr_addr_d;
    logic [7:0]              r_wr_data_q,   w_wr_data_d;
    logic                    r_wr_en_q,     w_wr_en_d;
    logic [ADDR_WIDTH-1:0]   r_rd_addr_q,   w_rd_addr_d;
    logic                    r_rd_en_q,     w_rd_en_d;
    logic                    r_overrun_q,   w_overrun_d;

    logic       w_rx_hex_valid;
    logic [3:0] w_rx_nibble;
    logic [3:0] w_tx_nibble;
    logic [7:0] w_tx_ascii;
    logic       w_timer_done;

    assign w_tx_nibble  = (r_state_q == c_ST_TX_HI) ? r_rdata_q[7:4] : r_rdata_q[3:0];
    assign w_timer_done = (r_timer_q == TIMEOUT_BITS'(TIMEOUT - 1));

    hex_nibble_ascii u_hex (
        .i_byte   (rx_data),
        .o_valid  (w_rx_hex_valid),
        .o_nibble (w_rx_nibble),
        .i_nibble (w_tx_nibble),
        .o_ascii  (w_tx_ascii)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= c_ST_IDLE;
            r_acc_q       <= '0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_rdata_q     <= '0;
            r_timer_q     <= '0;
            r_tx_data_q   <= '0;
            r_tx_strobe_q <= 1'b0;
            r_wr_addr_q   <= '0;
            r_wr_data_q   <= '0;
            r_wr_en_q     <= 1'b0;
            r_rd_addr_q   <= '0;
            r_rd_en_q     <= 1'b0;
            r_overrun_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_acc_q       <= w_acc_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_rdata_q     <= w_rdata_d;
            r_timer_q     <= w_timer_d;
            r_tx_data_q   <= w_tx_data_d;
            r_tx_strobe_q <= w_tx_strobe_d;
            r_wr_addr_q   <= w_wr_addr_d;
            r_wr_data_q   <= w_wr_data_d;
            r_wr_en_q     <= w_wr_en_d;
            r_rd_addr_q   <= w_rd_addr_d;
            r_rd_en_q     <= w_rd_en_d;
            r_overrun_q   <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (rx_strobe && !w_rx_hex_valid) begin
                    if (rx_data == c_ASCII_W) begin
                        w_state_d = c_ST_WR_WAIT;
                    end else if (rx_data == c_ASCII_R) begin
                        w_state_d = c_ST_RD_WAIT;
                    end
                end
            end
            c_ST_WR_WAIT: if (!sd_busy) w_state_d = c_ST_IDLE;
            c_ST_RD_WAIT: if (!sd_busy) w_state_d = c_ST_RD_DATA;
            c_ST_RD_DATA: begin
                if (sd_rd_ready) begin
                    w_state_d = c_ST_TX_HI;
                end else if (w_timer_done) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            c_ST_TX_HI: w_state_d = c_ST_TX_LO;
            c_ST_TX_LO: w_state_d = c_ST_TX_SP;
            c_ST_TX_SP: w_state_d = c_ST_IDLE;
            default:    w_state_d = c_ST_IDLE;
        endcase
    end

    // Strobes default low so every request and tx push is a single cycle.
    always_comb begin
        w_acc_d       = r_acc_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_rdata_d     = r_rdata_q;
        w_timer_d     = r_timer_q;
        w_tx_data_d   = r_tx_data_q;
        w_tx_strobe_d = 1'b0;
        w_wr_addr_d   = r_wr_addr_q;
        w_wr_data_d   = r_wr_data_q;
        w_wr_en_d     = 1'b0;
        w_rd_addr_d   = r_rd_addr_q;
        w_rd_en_d     = 1'b0;
        w_overrun_d   = r_overrun_q | (rx_strobe && (r_state_q != c_ST_IDLE));

        case (r_state_q)
            c_ST_IDLE: begin
                if (rx_strobe) begin
                    if (w_rx_hex_valid) begin
                        w_acc_d = {r_acc_q[ADDR_WIDTH-5:0], w_rx_nibble};
                    end else if (rx_data == c_ASCII_AT) begin
                        w_addr_d = r_acc_q;
                        w_acc_d  = '0;
                    end else if (rx_data == c_ASCII_X) begin
                        w_acc_d = '0;
                    end else if (rx_data == c_ASCII_W) begin
                        w_wdata_d = r_acc_q[7:0];
                        w_acc_d   = '0;
                    end
                end
            end
            c_ST_WR_WAIT: begin
                if (!sd_busy) begin
                    w_wr_en_d     = 1'b1;
                    w_wr_addr_d   = r_addr_q;
                    w_wr_data_d   = r_wdata_q;
                    w_addr_d      = r_addr_q + ADDR_WIDTH'(1);
                    w_tx_data_d   = c_ASCII_DOT;
                    w_tx_strobe_d = 1'b1;
                end
            end
            c_ST_RD_WAIT: begin
                if (!sd_busy) begin
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = r_addr_q;
                    w_timer_d   = '0;
                end
            end
            c_ST_RD_DATA: begin
                if (sd_rd_ready) begin
                    w_rdata_d = sd_rd_data;
                    w_addr_d  = r_addr_q + ADDR_WIDTH'(1);
                end else if (w_timer_done) begin
                    w_tx_data_d   = c_ASCII_QM;
                    w_tx_strobe_d = 1'b1;
                end else begin
                    w_timer_d = r_timer_q + TIMEOUT_BITS'(1);
                end
            end
            c_ST_TX_HI, c_ST_TX_LO: begin
                w_tx_data_d   = w_tx_ascii;
                w_tx_strobe_d = 1'b1;
            end
            c_ST_TX_SP: begin
                w_tx_data_d   = c_ASCII_SP;
                w_tx_strobe_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign tx_data      = r_tx_data_q;
    assign tx_strobe    = r_tx_strobe_q;
    assign sd_wr_addr   = r_wr_addr_q;
    assign sd_wr_data   = r_wr_data_q;
    assign sd_wr_enable = r_wr_en_q;
    assign sd_rd_addr   = r_rd_addr_q;
    assign sd_rd_enable = r_rd_en_q;
    assign overrun      = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_uart_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_uart_cmd
// Brief    : Self-checking bench for sdram_uart_cmd with a command-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_uart_cmd;

    localparam int AW  = 25;
    localparam int TO  = 1024;
    localparam int TOB = 11;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic [7:0]    rx_data     = 8'h00;
    logic          rx_strobe   = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_strobe;
    logic [AW-1:0] sd_wr_addr;
    logic [7:0]    sd_wr_data;
    logic          sd_wr_enable;
    logic [AW-1:0] sd_rd_addr;
    logic          sd_rd_enable;
    logic [7:0]    sd_rd_data  = 8'h00;
    logic          sd_rd_ready = 1'b0;
    logic          sd_busy     = 1'b0;
    logic          overrun;

    sdram_uart_cmd #(
        .ADDR_WIDTH   (AW),
        .TIMEOUT      (TO),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .tx_data      (tx_data),
        .tx_strobe    (tx_strobe),
        .sd_wr_addr   (sd_wr_addr),
        .sd_wr_data   (sd_wr_data),
        .sd_wr_enable (sd_wr_enable),
        .sd_rd_addr   (sd_rd_addr),
        .sd_rd_enable (sd_rd_enable),
        .sd_rd_data   (sd_rd_data),
        .sd_rd_ready  (sd_rd_ready),
        .sd_busy      (sd_busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int both_cnt = 0;
    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_strobe === 1'b1) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (sd_wr_enable === 1'b1) wr_cnt++;
        if (sd_rd_enable === 1'b1) rd_cnt++;
        if (sd_wr_enable === 1'b1 && sd_rd_enable === 1'b1) both_cnt++;
    end

    // Command-level model: what an IDLE-consumed byte does to acc/addr/wdata.
    logic [AW-1:0] m_acc   = '0;
    logic [AW-1:0] m_addr  = '0;
    logic [7:0]    m_wdata = 8'h00;

    function automatic void model_byte(input logic [7:0] b);
        int     v;
        longint t;
        v = -1;
        if (b >= 8'h30 && b <= 8'h39)      v = int'(b) - 'h30;
        else if (b >= 8'h61 && b <= 8'h66) v = int'(b) - 'h61 + 10;
        else if (b >= 8'h41 && b <= 8'h46) v = int'(b) - 'h41 + 10;
        if (v >= 0) begin
            t     = longint'(m_acc) * 16 + longint'(v);
            m_acc = t[AW-1:0];
        end else if (b == 8'h40) begin
            m_addr = m_acc;
            m_acc  = '0;
        end else if (b == 8'h78) begin
            m_acc = '0;
        end else if (b == 8'h77) begin
            m_wdata = m_acc[7:0];
            m_acc   = '0;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] b);
        send_byte(b);
        model_byte(b);
    endtask

    task automatic send_text(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic send_hex(input logic [31:0] v, input int nd);
        logic [3:0] nib;
        logic [7:0] ch;
        for (int i = nd - 1; i >= 0; i--) begin
            nib = 4'((v >> (4 * i)) & 32'hF);
            if (nib < 4'd10)              ch = 8'h30 + {4'h0, nib};
            else if ($urandom_range(0, 1)) ch = 8'h41 + {4'h0, nib} - 8'd10;
            else                           ch = 8'h61 + {4'h0, nib} - 8'd10;
            if ($urandom_range(0, 4) == 0) send_char(8'h20);
            send_char(ch);
        end
    endtask

    task automatic do_write(input int busy_cycles);
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        int            n0;
        sd_busy = (busy_cycles > 0);
        send_char(8'h77);
        ea = m_addr;
        ed = m_wdata;
        if (busy_cycles > 0) begin
            n0 = wr_cnt;
            repeat (busy_cycles) @(posedge clk);
            #1;
            checks++;
            if (wr_cnt != n0) begin
                errors++;
                $display("FAIL wr_while_busy: got %0d pulses, expected 0", wr_cnt - n0);
            end
            sd_busy = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (sd_wr_enable !== 1'b0) begin
            errors++;
            $display("FAIL wr_early: got %b, expected 0", sd_wr_enable);
        end
        @(negedge clk);
        checks++;
        if (sd_wr_enable !== 1'b1) begin
            errors++;
            $display("FAIL wr_enable: got %b, expected 1", sd_wr_enable);
        end
        checks++;
        if (sd_wr_addr !== ea) begin
            errors++;
            $display("FAIL wr_addr: got %h, expected %h", sd_wr_addr, ea);
        end
        checks++;
        if (sd_wr_data !== ed) begin
            errors++;
            $display("FAIL wr_data: got %h, expected %h", sd_wr_data, ed);
        end
        checks++;
        if (tx_strobe !== 1'b1 || tx_data !== 8'h2E) begin
            errors++;
            $display("FAIL wr_ack: got strobe %b data %h, expected 1 2e", tx_strobe, tx_data);
        end
        @(negedge clk);
        checks++;
        if (sd_wr_enable !== 1'b0) begin
            errors++;
            $display("FAIL wr_single_pulse: got %b, expected 0", sd_wr_enable);
        end
        m_addr = m_addr + AW'(1);
    endtask

    task automatic do_read(input int busy_cycles, input logic [7:0] d, input int delay);
        logic [AW-1:0] ea;
        int            n0, t0, k;
        string         exp_s;
        sd_busy = (busy_cycles > 0);
        send_char(8'h72);
        ea = m_addr;
        t0 = tx_q.size();
        if (busy_cycles > 0) begin
            n0 = rd_cnt;
            repeat (busy_cycles) @(posedge clk);
            #1;
            checks++;
            if (rd_cnt != n0) begin
                errors++;
                $display("FAIL rd_while_busy: got %0d pulses, expected 0", rd_cnt - n0);
            end
            sd_busy = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (sd_rd_enable !== 1'b0) begin
            errors++;
            $display("FAIL rd_early: got %b, expected 0", sd_rd_enable);
        end
        @(negedge clk);
        checks++;
        if (sd_rd_enable !== 1'b1 || sd_rd_addr !== ea) begin
            errors++;
            $display("FAIL rd_request: got en %b addr %h, expected 1 %h", sd_rd_enable, sd_rd_addr, ea);
        end
        repeat (delay) @(posedge clk);
        #1;
        sd_rd_ready = 1'b1;
        sd_rd_data  = d;
        @(posedge clk);
        #1;
        k           = cyc;
        sd_rd_ready = 1'b0;
        sd_rd_data  = 8'($urandom);
        repeat (6) @(negedge clk);
        exp_s = $sformatf("%02x ", d);
        checks++;
        if (tx_q.size() != t0 + 3) begin
            errors++;
            $display("FAIL rd_tx_count: got %0d bytes, expected 3", tx_q.size() - t0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tx_q[t0+i] !== exp_s[i] || tx_cyc_q[t0+i] != k + 1 + i) begin
                    errors++;
                    $display("FAIL rd_tx[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                             i, tx_q[t0+i], tx_cyc_q[t0+i], exp_s[i], k + 1 + i);
                end
            end
        end
        m_addr = m_addr + AW'(1);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (tx_strobe !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL %s_tx: got %b/%h, expected 0/00", tag, tx_strobe, tx_data);
        end
        checks++;
        if (sd_wr_enable !== 1'b0 || sd_wr_addr !== '0 || sd_wr_data !== 8'h00) begin
            errors++;
            $display("FAIL %s_wr: got %b/%h/%h, expected all 0", tag, sd_wr_enable, sd_wr_addr, sd_wr_data);
        end
        checks++;
        if (sd_rd_enable !== 1'b0 || sd_rd_addr !== '0) begin
            errors++;
            $display("FAIL %s_rd: got %b/%h, expected all 0", tag, sd_rd_enable, sd_rd_addr);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s_overrun: got %b, expected 0", tag, overrun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_acc  = '0;
        m_addr = '0;
    endtask

    task automatic test_write_basic();
        send_text("123@55");
        do_write(0);
    endtask

    task automatic test_read_basic();
        send_text("123@");
        do_read(0, 8'hA7, 6);
        send_text("77");
        do_write(0);
    endtask

    task automatic test_busy();
        send_text("9");
        do_write(20);
        do_read(5, 8'h3C, 2);
    endtask

    task automatic test_ignored();
        int t0;
        t0 = tx_q.size();
        send_text("3c");
        send_char(8'h0D);
        send_char(8'h0A);
        send_char(8'h20);
        send_char(8'h7A);
        send_char(8'h47);
        send_char(8'h40);
        repeat (4) @(negedge clk);
        checks++;
        if (tx_q.size() != t0) begin
            errors++;
            $display("FAIL ignored_tx: got %0d bytes, expected 0", tx_q.size() - t0);
        end
        send_text("5a");
        do_write(0);
    endtask

    task automatic test_timeout();
        int t0, c0, n0;
        n0      = rd_cnt;
        sd_busy = 1'b0;
        send_char(8'h72);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sd_rd_enable !== 1'b1) begin
            errors++;
            $display("FAIL to_request: got %b, expected 1", sd_rd_enable);
        end
        c0 = cyc;
        t0 = tx_q.size();
        repeat (TO + 4) @(negedge clk);
        checks++;
        if (tx_q.size() != t0 + 1) begin
            errors++;
            $display("FAIL to_tx_count: got %0d bytes, expected 1", tx_q.size() - t0);
        end else begin
            checks++;
            if (tx_q[t0] !== 8'h3F || tx_cyc_q[t0] - c0 != TO) begin
                errors++;
                $display("FAIL to_tx: got %h after %0d cycles, expected 3f after %0d",
                         tx_q[t0], tx_cyc_q[t0] - c0, TO);
            end
        end
        @(posedge clk);
        #1;
        sd_rd_ready = 1'b1;
        @(posedge clk);
        #1;
        sd_rd_ready = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (tx_q.size() != t0 + 1 || rd_cnt != n0 + 1) begin
            errors++;
            $display("FAIL to_late_ready: got %0d tx %0d rd, expected 1 tx 1 rd",
                     tx_q.size() - t0, rd_cnt - n0);
        end
        send_text("12");
        do_write(0);
    endtask

    task automatic test_wrap();
        send_text("1FFFFFF@");
        do_read(0, 8'h00, 3);
        send_text("42");
        do_write(0);
        // Nine digits into a 25-bit accumulator keep only the low 25 bits.
        send_text("123456789@");
        send_text("11");
        do_write(0);
    endtask

    task automatic test_overrun();
        int t0;
        send_text("2b7");
        sd_busy = 1'b0;
        send_char(8'h72);
        t0 = tx_q.size();
        @(negedge clk);
        @(negedge clk);
        send_byte(8'h35);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, expected 1", overrun);
        end
        sd_rd_ready = 1'b1;
        sd_rd_data  = 8'h3C;
        @(posedge clk);
        #1;
        sd_rd_ready = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (tx_q.size() != t0 + 3 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_read: got %0d tx overrun %b, expected 3 tx overrun 1",
                     tx_q.size() - t0, overrun);
        end
        m_addr = m_addr + AW'(1);
        send_char(8'h40);
        send_text("66");
        do_write(0);
    endtask

    task automatic test_reset_mid_read();
        int t0;
        send_text("44");
        sd_busy = 1'b0;
        send_char(8'h72);
        @(negedge clk);
        @(negedge clk);
        t0 = tx_q.size();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset       = 1'b0;
        sd_rd_ready = 1'b1;
        @(posedge clk);
        #1;
        sd_rd_ready = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (tx_q.size() != t0) begin
            errors++;
            $display("FAIL mid_reset_tx: got %0d bytes, expected 0", tx_q.size() - t0);
        end
        m_acc  = '0;
        m_addr = '0;
        send_text("5a");
        do_write(0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                send_hex($urandom, int'($urandom_range(1, 8)));
                send_char(8'h40);
            end
            if ($urandom_range(0, 1) == 0) begin
                send_hex($urandom_range(0, 255), 2);
                do_write(int'($urandom_range(0, 4)));
            end else begin
                do_read(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(1, 8)));
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL wr_rd_exclusive: got %0d overlapping cycles, expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_busy();
        test_ignored();
        test_timeout();
        test_wrap();
        test_overrun();
        test_reset_mid_read();
        test_random();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
